// File: rtl/div_sequencial.sv
// div_sequencial
// Sequential signed 32-bit restoring divider serving the control unit's
// start/stop handshake for the MIPS `div` instruction. One quotient bit is
// produced per clock. The quotient is returned on `lo` and the remainder on
// `hi`. A zero divisor is reported through `div_zero` instead of a result.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   start     request from the control unit, sampled only while idle
//   dividend  signed dividend (rs)
//   divisor   signed divisor (rt)
//   hi        signed remainder of the last completed division
//   lo        signed quotient of the last completed division
//   done      one-cycle completion pulse
//   busy      high from start acceptance until the done cycle
//   div_zero  last accepted request had a zero divisor
module div_sequencial (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done,
  output logic        busy,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt;

  logic [31:0] quo_r;        // dividend magnitude shifting out, quotient shifting in
  logic [31:0] quo_nxt;
  logic [31:0] dvs_r;        // divisor magnitude
  logic [31:0] dvs_nxt;
  logic [32:0] rem_r;        // partial remainder accumulator
  logic [32:0] rem_nxt;
  logic [5:0]  cnt_r;
  logic [5:0]  cnt_nxt;
  logic        sign_q_r;
  logic        sign_q_nxt;
  logic        sign_rem_r;
  logic        sign_rem_nxt;
  logic        zero_r;       // accepted request had a zero divisor
  logic        zero_nxt;

  logic [31:0] hi_nxt;
  logic [31:0] lo_nxt;
  logic        done_nxt;
  logic        busy_nxt;
  logic        div_zero_nxt;

  logic [33:0] rem_shift;
  logic [33:0] rem_diff;

  // Two's-complement negation truncated to 32 bits.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    neg32 = ~v + 32'd1;
  endfunction

  // Unsigned magnitude of a signed value; 0x80000000 maps to 2^31.
  function automatic logic [31:0] magnitude(input logic [31:0] v);
    magnitude = v[31] ? neg32(v) : v;
  endfunction

  // Shift the next dividend bit into the remainder and trial-subtract.
  // Bit 33 of the difference is the borrow: set when the shifted
  // remainder is smaller than the divisor magnitude.
  always_comb begin
    rem_shift = {rem_r, quo_r[31]};
    rem_diff  = rem_shift - {2'b00, dvs_r};
  end

  // Next-state and next-output logic for the divider FSM.
  always_comb begin
    state_nxt    = state_r;
    quo_nxt      = quo_r;
    dvs_nxt      = dvs_r;
    rem_nxt      = rem_r;
    cnt_nxt      = cnt_r;
    sign_q_nxt   = sign_q_r;
    sign_rem_nxt = sign_rem_r;
    zero_nxt     = zero_r;
    hi_nxt       = hi;
    lo_nxt       = lo;
    done_nxt     = 1'b0;
    busy_nxt     = busy;
    div_zero_nxt = div_zero;

    case (state_r)
      IDLE: begin
        if (start) begin
          quo_nxt      = magnitude(dividend);
          dvs_nxt      = magnitude(divisor);
          sign_q_nxt   = dividend[31] ^ divisor[31];
          sign_rem_nxt = dividend[31];
          rem_nxt      = 33'd0;
          cnt_nxt      = 6'd0;
          div_zero_nxt = 1'b0;
          busy_nxt     = 1'b1;
          zero_nxt     = (divisor == 32'd0);
          state_nxt    = (divisor == 32'd0) ? FIX : RUN;
        end else begin
          state_nxt    = IDLE;
        end
      end

      RUN: begin
        if (!rem_diff[33]) begin
          rem_nxt = rem_diff[32:0];
          quo_nxt = {quo_r[30:0], 1'b1};
        end else begin
          rem_nxt = rem_shift[32:0];
          quo_nxt = {quo_r[30:0], 1'b0};
        end
        cnt_nxt = cnt_r + 6'd1;
        if (cnt_r == 6'd31) begin
          state_nxt = FIX;
        end else begin
          state_nxt = RUN;
        end
      end

      FIX: begin
        if (zero_r) begin
          // Results from the previous division are left untouched.
          div_zero_nxt = 1'b1;
        end else begin
          lo_nxt = sign_q_r   ? neg32(quo_r)       : quo_r;
          hi_nxt = sign_rem_r ? neg32(rem_r[31:0]) : rem_r[31:0];
        end
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Datapath and registered output updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      quo_r      <= 32'd0;
      dvs_r      <= 32'd0;
      rem_r      <= 33'd0;
      cnt_r      <= 6'd0;
      sign_q_r   <= 1'b0;
      sign_rem_r <= 1'b0;
      zero_r     <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      done       <= 1'b0;
      busy       <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      quo_r      <= quo_nxt;
      dvs_r      <= dvs_nxt;
      rem_r      <= rem_nxt;
      cnt_r      <= cnt_nxt;
      sign_q_r   <= sign_q_nxt;
      sign_rem_r <= sign_rem_nxt;
      zero_r     <= zero_nxt;
      hi         <= hi_nxt;
      lo         <= lo_nxt;
      done       <= done_nxt;
      busy       <= busy_nxt;
      div_zero   <= div_zero_nxt;
    end
  end

endmodule
